// File: rtl/set_pattern_driver_if.sv
// Request/response bundle between the pattern driver (master) and the SET
// circle-candidate engine (slave).
interface set_pattern_driver_if;
    logic        en;
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic        busy;
    logic        valid;
    logic [7:0]  candidate;

    modport master (
        output en, central, radius, mode,
        input  busy, valid, candidate
    );

    modport slave (
        input  en, central, radius, mode,
        output busy, valid, candidate
    );
endinterface

// File: rtl/set_pattern_driver.sv
// On-chip self-test driver for SET: walks a synchronous pattern ROM, issues each
// triple over the busy/en handshake and scores the returned candidates.
module set_pattern_driver #(
    parameter int NUM_PAT = 64,
    parameter int ADDR_W  = 6,
    parameter int MAX_ERR = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode_cfg,
    output logic [ADDR_W-1:0]   pat_addr,
    input  logic [23:0]         pat_central,
    input  logic [11:0]         pat_radius,
    input  logic [7:0]          pat_expected,
    set_pattern_driver_if.master set_bus,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [7:0]          err_cnt,
    output logic [ADDR_W-1:0]   fail_idx
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_IDLE, S_ISSUE, S_WAIT_VALID, S_CHECK, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] fail_idx_q, fail_idx_d;
    logic [23:0]       central_q, central_d;
    logic [11:0]       radius_q, radius_d;
    logic [1:0]        mode_q, mode_d;
    logic [7:0]        exp_q, exp_d;
    logic [7:0]        cand_q, cand_d;
    logic [7:0]        err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              wd_expired;

    // The watchdog has spent TIMEOUT cycles in the current wait state.
    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        idx_d      = idx_q;
        fail_idx_d = fail_idx_q;
        central_d  = central_q;
        radius_d   = radius_q;
        mode_d     = mode_q;
        exp_d      = exp_q;
        cand_d     = cand_q;
        err_d      = err_q;
        wd_d       = wd_q;
        done_d     = done_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    idx_d      = '0;
                    fail_idx_d = '0;
                    err_d      = '0;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    mode_d     = mode_cfg;
                end
            end
            S_FETCH: begin
                wd_d    = '0;
                state_d = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                wd_d = wd_q + WD_W'(1);
                // ROM data for pat_addr becomes valid in the first cycle here.
                if (wd_q == '0) begin
                    central_d = pat_central;
                    radius_d  = pat_radius;
                    exp_d     = pat_expected;
                end
                if (!set_bus.busy) begin
                    state_d = S_ISSUE;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT_VALID;
            end
            S_WAIT_VALID: begin
                wd_d = wd_q + WD_W'(1);
                if (set_bus.valid) begin
                    cand_d  = set_bus.candidate;
                    state_d = S_CHECK;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_CHECK: begin
                if (cand_q != exp_q && err_q != 8'(MAX_ERR)) begin
                    err_d = err_q + 8'd1;
                    if (err_q == '0) fail_idx_d = idx_q;
                end
                if (idx_q == ADDR_W'(NUM_PAT - 1) || err_d == 8'(MAX_ERR)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            fail_idx_q <= '0;
            central_q  <= '0;
            radius_q   <= '0;
            mode_q     <= '0;
            exp_q      <= '0;
            cand_q     <= '0;
            err_q      <= '0;
            wd_q       <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            idx_q      <= idx_d;
            fail_idx_q <= fail_idx_d;
            central_q  <= central_d;
            radius_q   <= radius_d;
            mode_q     <= mode_d;
            exp_q      <= exp_d;
            cand_q     <= cand_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    // en decodes straight from the state flop, so reset drops it asynchronously.
    assign set_bus.en      = (state_q == S_ISSUE);
    assign set_bus.central = central_q;
    assign set_bus.radius  = radius_q;
    assign set_bus.mode    = mode_q;

    assign pat_addr = idx_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign err_cnt  = err_q;
    assign fail_idx = fail_idx_q;
    assign pass     = done_q && (err_q == '0) && !timeout_q;

endmodule

// File: tb/tb_set_pattern_driver.sv
// Self-checking bench for set_pattern_driver: random pattern ROM, behavioural SET
// engine with fault injection, and a run-level outcome predictor.
module tb_set_pattern_driver;
  localparam int NUM_PAT = 64;
  localparam int ADDR_W  = 6;
  localparam int MAX_ERR = 10;
  localparam int TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        mode_cfg = '0;
  logic [ADDR_W-1:0] pat_addr;
  logic [23:0]       pat_central;
  logic [11:0]       pat_radius;
  logic [7:0]        pat_expected;
  logic              done, pass, timeout;
  logic [7:0]        err_cnt;
  logic [ADDR_W-1:0] fail_idx;

  set_pattern_driver_if set_bus ();

  set_pattern_driver #(
    .NUM_PAT(NUM_PAT), .ADDR_W(ADDR_W), .MAX_ERR(MAX_ERR), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode_cfg(mode_cfg),
    .pat_addr(pat_addr), .pat_central(pat_central), .pat_radius(pat_radius),
    .pat_expected(pat_expected), .set_bus(set_bus),
    .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Pattern ROM contents and the triples actually seen on the SET bus.
  logic [23:0] rom_c [NUM_PAT];
  logic [11:0] rom_r [NUM_PAT];
  logic [7:0]  rom_e [NUM_PAT];
  logic [23:0] log_c [NUM_PAT];
  logic [11:0] log_r [NUM_PAT];

  // Fault-injection controls (written only by the stimulus process).
  logic [63:0] corrupt_mask = '0;
  bit          corrupt_all = 1'b0;
  int          hold_idx = -1;
  int          issue_base = 0;

  // Bookkeeping owned by the SET model.
  int n_en = 0;
  int busy_viol = 0;
  int en_wide = 0;

  function automatic logic [7:0] set_ref(input logic [23:0] c, input logic [11:0] r);
    return (c[7:0] + c[15:8] + c[23:16]) ^ r[7:0] ^ {r[11:8], 4'h0};
  endfunction

  // Outcome of a whole run from the counting rules alone.
  function automatic void predict(input logic [63:0] m, input bit all,
                                  output int n, output int e, output int f);
    n = 0; e = 0; f = 0;
    for (int i = 0; i < NUM_PAT; i++) begin
      n++;
      if (all || m[i]) begin
        if (e == 0) f = i;
        e++;
      end
      if (e == MAX_ERR) break;
    end
  endfunction

  function automatic int log_bad(input int n);
    int bad = 0;
    for (int k = 0; k < n && k < NUM_PAT; k++)
      if (log_c[k] !== rom_c[k] || log_r[k] !== rom_r[k]) bad++;
    return bad;
  endfunction

  always @(posedge clk) begin
    pat_central  <= rom_c[pat_addr];
    pat_radius   <= rom_r[pat_addr];
    pat_expected <= rom_e[pat_addr];
  end

  // SET engine: busy one cycle after en, valid eight cycles after that.
  logic [23:0] cur_c;
  logic [11:0] cur_r;
  int          cur_k = 0;
  int          age = 0;
  bit          pend = 1'b0;
  bit          en_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      set_bus.busy      = 1'b0;
      set_bus.valid     = 1'b0;
      set_bus.candidate = '0;
      pend              = 1'b0;
      en_prev           = 1'b0;
    end else begin
      set_bus.valid = 1'b0;
      if (set_bus.en) begin
        if (set_bus.busy) busy_viol++;
        if (en_prev) en_wide++;
        cur_k = n_en - issue_base;
        cur_c = set_bus.central;
        cur_r = set_bus.radius;
        if (cur_k >= 0 && cur_k < NUM_PAT) begin
          log_c[cur_k] = cur_c;
          log_r[cur_k] = cur_r;
        end
        n_en++;
        pend = 1'b1;
        age  = 0;
      end else if (pend) begin
        age++;
        if (age == 1) set_bus.busy = 1'b1;
        if (age == 9) begin
          set_bus.valid     = 1'b1;
          set_bus.candidate = set_ref(cur_c, cur_r) +
                              ((corrupt_all || corrupt_mask[cur_k[5:0]]) ? 8'd1 : 8'd0);
          set_bus.busy      = (cur_k == hold_idx);
          pend              = 1'b0;
        end
      end
      en_prev = set_bus.en;
    end
  end

  task automatic load_rom();
    for (int i = 0; i < NUM_PAT; i++) begin
      rom_c[i] = 24'($urandom);
      rom_r[i] = 12'($urandom);
      rom_e[i] = set_ref(rom_c[i], rom_r[i]);
    end
  endtask

  task automatic begin_run(input logic [63:0] m, input bit all, input int hold);
    load_rom();
    corrupt_mask = m;
    corrupt_all  = all;
    hold_idx     = hold;
    issue_base   = n_en;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    mode_cfg = m;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    mode_cfg = ~m;
  endtask

  task automatic wait_done(input int budget, input string name);
    int cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done_wait: done=%b after %0d cycles, want 1", name, done, cyc);
    end
  endtask

  task automatic wait_issued(input int k, input int budget, input string name);
    int cyc = 0;
    while (n_en - issue_base < k && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (n_en - issue_base < k) begin
      miscompares++;
      $display("FAIL %s_issue_wait: issued=%0d want %0d", name, n_en - issue_base, k);
    end
  endtask

  function automatic logic [61:0] all_outputs();
    return {set_bus.en, set_bus.central, set_bus.radius, set_bus.mode, pat_addr,
            done, pass, timeout, err_cnt, fail_idx};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (all_outputs() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", all_outputs());
    end
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({set_bus.en, done, pat_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_idle_hold: en/done/addr=%b want 0", {set_bus.en, done, pat_addr});
    end
  endtask

  task automatic test_all_pass();
    int n, e, f;
    begin_run('0, 1'b0, -1);
    pulse_start(2'b00);
    wait_done(3000, "pass");
    predict('0, 1'b0, n, e, f);
    vectors++;
    if ({pass, timeout, set_bus.mode} !== 4'b1000) begin
      miscompares++;
      $display("FAIL pass_status: pass/timeout/mode=%b want 1000", {pass, timeout, set_bus.mode});
    end
    vectors++;
    if (err_cnt !== 8'(e) || fail_idx !== ADDR_W'(f)) begin
      miscompares++;
      $display("FAIL pass_counts: err=%0d idx=%0d want %0d %0d", err_cnt, fail_idx, e, f);
    end
    vectors++;
    if (n_en - issue_base !== n) begin
      miscompares++;
      $display("FAIL pass_en_pulses: got %0d want %0d", n_en - issue_base, n);
    end
    vectors++;
    if (log_bad(n) !== 0) begin
      miscompares++;
      $display("FAIL pass_bus_data: %0d wrong triples want 0", log_bad(n));
    end
    vectors++;
    if (en_wide !== 0 || busy_viol !== 0) begin
      miscompares++;
      $display("FAIL pass_handshake: wide=%0d busy_viol=%0d want 0 0", en_wide, busy_viol);
    end
  endtask

  task automatic test_corrupt();
    int n, e, f;
    logic [63:0] m;
    for (int r = 0; r < 3; r++) begin
      m = '0;
      if (r == 0) begin
        m[5]  = 1'b1;
        m[40] = 1'b1;
      end else begin
        repeat ($urandom_range(1, 8 * r)) m[$urandom_range(63, 0)] = 1'b1;
      end
      begin_run(m, 1'b0, -1);
      pulse_start(2'($urandom_range(3, 0)));
      wait_done(3000, "corrupt");
      predict(m, 1'b0, n, e, f);
      vectors++;
      if (err_cnt !== 8'(e) || fail_idx !== ADDR_W'(f)) begin
        miscompares++;
        $display("FAIL corrupt%0d_counts: err=%0d idx=%0d want %0d %0d", r, err_cnt, fail_idx, e, f);
      end
      vectors++;
      if (pass !== 1'b0 || timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL corrupt%0d_status: pass=%b timeout=%b want 0 0", r, pass, timeout);
      end
      vectors++;
      if (n_en - issue_base !== n) begin
        miscompares++;
        $display("FAIL corrupt%0d_en_pulses: got %0d want %0d", r, n_en - issue_base, n);
      end
    end
  endtask

  task automatic test_corrupt_all();
    int n, e, f;
    begin_run('0, 1'b1, -1);
    pulse_start(2'b10);
    wait_done(3000, "abort");
    predict('0, 1'b1, n, e, f);
    vectors++;
    if (err_cnt !== 8'(e) || fail_idx !== ADDR_W'(f)) begin
      miscompares++;
      $display("FAIL abort_counts: err=%0d idx=%0d want %0d %0d", err_cnt, fail_idx, e, f);
    end
    vectors++;
    if (n_en - issue_base !== n) begin
      miscompares++;
      $display("FAIL abort_en_pulses: got %0d want %0d", n_en - issue_base, n);
    end
    vectors++;
    if ({pass, timeout} !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_status: pass/timeout=%b want 00", {pass, timeout});
    end
  endtask

  task automatic test_timeout();
    int cyc = 0;
    begin_run('0, 1'b0, 3);
    pulse_start(2'b01);
    wait_issued(4, 500, "timeout");
    while (done !== 1'b1 && cyc < TIMEOUT + 200) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if ({done, timeout, pass} !== 3'b110) begin
      miscompares++;
      $display("FAIL timeout_status: done/timeout/pass=%b want 110", {done, timeout, pass});
    end
    vectors++;
    if (cyc < TIMEOUT || cyc > TIMEOUT + 40) begin
      miscompares++;
      $display("FAIL timeout_latency: %0d cycles, want %0d..%0d", cyc, TIMEOUT, TIMEOUT + 40);
    end
    vectors++;
    if (n_en - issue_base !== 4 || busy_viol !== 0 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL timeout_issue: pulses=%0d busy_viol=%0d err=%0d want 4 0 0",
               n_en - issue_base, busy_viol, err_cnt);
    end
    hold_idx = -1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n, e, f;
    begin_run('0, 1'b0, -1);
    pulse_start(2'b01);
    wait_issued(21, 1000, "midrst");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (all_outputs() !== '0 || set_bus.en !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got %h want 0", all_outputs());
    end
    @(negedge clk);
    #1 rst = 1'b0;
    begin_run('0, 1'b0, -1);
    pulse_start(2'b11);
    vectors++;
    if (pat_addr !== '0 || set_bus.mode !== 2'b11 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_restart: addr=%0d mode=%b done=%b want 0 11 0", pat_addr, set_bus.mode, done);
    end
    wait_done(3000, "midrst");
    predict('0, 1'b0, n, e, f);
    vectors++;
    if (pass !== 1'b1 || n_en - issue_base !== n || log_bad(n) !== 0) begin
      miscompares++;
      $display("FAIL midrst_rerun: pass=%b pulses=%0d bad=%0d want 1 %0d 0",
               pass, n_en - issue_base, log_bad(n), n);
    end
  endtask

  task automatic test_back_to_back();
    int n, e, f;
    logic [63:0] m;
    m = 64'd1 << 2;
    begin_run(m, 1'b0, -1);
    pulse_start(2'b01);
    wait_issued(8, 1000, "ignore");
    pulse_start(2'b10);
    vectors++;
    if (set_bus.mode !== 2'b01 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_midrun_start: mode=%b done=%b want 01 0", set_bus.mode, done);
    end
    wait_done(3000, "ignore");
    predict(m, 1'b0, n, e, f);
    vectors++;
    if (err_cnt !== 8'(e) || fail_idx !== ADDR_W'(f) || n_en - issue_base !== n) begin
      miscompares++;
      $display("FAIL ignore_result: err=%0d idx=%0d pulses=%0d want %0d %0d %0d",
               err_cnt, fail_idx, n_en - issue_base, e, f, n);
    end
    begin_run('0, 1'b0, -1);
    pulse_start(2'b00);
    vectors++;
    if ({done, err_cnt, fail_idx} !== '0) begin
      miscompares++;
      $display("FAIL rerun_clear: done/err/idx=%b want 0", {done, err_cnt, fail_idx});
    end
    wait_done(3000, "rerun");
    predict('0, 1'b0, n, e, f);
    vectors++;
    if (pass !== 1'b1 || n_en - issue_base !== n || log_bad(n) !== 0) begin
      miscompares++;
      $display("FAIL rerun_result: pass=%b pulses=%0d bad=%0d want 1 %0d 0",
               pass, n_en - issue_base, log_bad(n), n);
    end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_corrupt();
    test_corrupt_all();
    test_timeout();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit: simulation still running, want finished");
    $fatal(1, "time limit");
  end

endmodule
